divide_by_n: RTL and testbench



---
 rtl/divide_by_n.sv | 91 +++++++++
 tb/tb_divide_by_n.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/divide_by_n.sv
// divide_by_n: runtime-programmable modulo-N divider with pulse or
// near-50% square-wave output. Divisor/mode changes are staged and only
// take effect at a period boundary so no period is ever truncated.
module divide_by_n #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] div,
    input  logic             mode,
    input  logic             div_load,
    output logic             q,
    output logic             tick,
    output logic             div_err
);

    localparam longint unsigned MAX_DIV = (64'd1 << WIDTH) - 64'd1;

    if (DEFAULT_DIV < 2 || 64'(DEFAULT_DIV) > MAX_DIV) begin : g_bad_default
        $fatal(1, "divide_by_n: DEFAULT_DIV out of range 2..2^WIDTH-1");
    end

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_cur_div;
    logic             r_cur_mode;
    logic [WIDTH-1:0] r_pend_div;
    logic             r_pend_mode;
    logic             r_pend_valid;
    logic             r_div_err;

    logic             w_last;
    logic             w_wrap;
    logic             w_load_ok;
    logic [WIDTH-1:0] w_half;

    // Decode of registered state: end-of-period, wrap and load validity.
    always_comb begin
        w_last    = (r_cnt == r_cur_div - WIDTH'(1));
        w_wrap    = en & w_last;
        w_load_ok = div_load & (div >= WIDTH'(2));
        // ceil(cur_div/2) without needing an extra bit of width
        w_half    = (r_cur_div >> 1) + {{(WIDTH-1){1'b0}}, r_cur_div[0]};
    end

    // Counter, active divisor/mode and staged-load registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_cur_div    <= WIDTH'(DEFAULT_DIV);
            r_cur_mode   <= 1'b0;
            r_pend_div   <= '0;
            r_pend_mode  <= 1'b0;
            r_pend_valid <= 1'b0;
            r_div_err    <= 1'b0;
        end else begin
            r_div_err <= div_load & ~w_load_ok;
            if (w_wrap) begin
                r_cnt <= '0;
                // A valid load arriving on the wrap itself bypasses staging.
                if (w_load_ok) begin
                    r_cur_div    <= div;
                    r_cur_mode   <= mode;
                    r_pend_valid <= 1'b0;
                end else if (r_pend_valid) begin
                    r_cur_div    <= r_pend_div;
                    r_cur_mode   <= r_pend_mode;
                    r_pend_valid <= 1'b0;
                end
            end else begin
                if (en) begin
                    r_cnt <= r_cnt + WIDTH'(1);
                end
                if (w_load_ok) begin
                    r_pend_div   <= div;
                    r_pend_mode  <= mode;
                    r_pend_valid <= 1'b1;
                end
            end
        end
    end

    // Outputs come from registered state only.
    always_comb begin
        q       = r_cur_mode ? (r_cnt < w_half) : (r_cnt == '0);
        tick    = w_last;
        div_err = r_div_err;
    end

endmodule

// File: tb/tb_divide_by_n.sv
// Directed testbench for divide_by_n with a period-level reference model.
module tb_divide_by_n;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned DEF_DIV = 3;

    logic             clk;
    logic             reset;
    logic             en;
    logic [WIDTH-1:0] div;
    logic             mode;
    logic             div_load;
    logic             q;
    logic             tick;
    logic             div_err;

    int checks   = 0;
    int failures = 0;

    divide_by_n #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .div      (div),
        .mode     (mode),
        .div_load (div_load),
        .q        (q),
        .tick     (tick),
        .div_err  (div_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: position inside the current period, period length, shape,
    // and an optional staged request (last one wins).
    typedef struct {
        bit valid;
        int pos;
        int n;
        bit shape;
        bit pv;
        int pn;
        bit pm;
        bit err;
    } mstate_t;

    mstate_t m = '{default: 0};

    function automatic mstate_t model_next(mstate_t s, bit rst, bit e, int d, bit md, bit ld);
        mstate_t r = s;
        bit good;
        if (rst) begin
            r.valid = 1; r.pos = 0; r.n = DEF_DIV; r.shape = 0; r.pv = 0; r.err = 0;
            return r;
        end
        good  = ld && (d >= 2);
        r.err = ld && (d < 2);
        if (e && s.pos == s.n - 1) begin
            r.pos = 0;
            if (good) begin
                r.n = d; r.shape = md; r.pv = 0;
            end else if (s.pv) begin
                r.n = s.pn; r.shape = s.pm; r.pv = 0;
            end
        end else begin
            if (e) r.pos = s.pos + 1;
            if (good) begin
                r.pv = 1; r.pn = d; r.pm = md;
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        m <= model_next(m, reset, en, int'(div), mode, div_load);
    end

    task automatic chk(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b t=%0t", nm, got, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (m.valid) begin
            chk("model_q", q, m.shape ? (2 * m.pos < m.n) : (m.pos == 0));
            chk("model_tick", tick, m.pos == m.n - 1);
            chk("model_div_err", div_err, m.err);
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_load(input int d, input bit md);
        div_load = 1'b1;
        div      = WIDTH'(d);
        mode     = md;
        @(negedge clk);
        div_load = 1'b0;
    endtask

    // Patterns are written first-sample-first (MSB of the n-bit field).
    task automatic expect_run(input string nm, input int n, input logic [31:0] qp, input logic [31:0] tp);
        for (int i = 0; i < n; i++) begin
            chk({nm, "_q"}, q, qp[n-1-i]);
            chk({nm, "_tick"}, tick, tp[n-1-i]);
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; en = 1'b1; div = '0; mode = 1'b0; div_load = 1'b0;
        @(negedge clk);
        chk("reset_q", q, 1'b1);
        chk("reset_tick", tick, 1'b0);
        chk("reset_err", div_err, 1'b0);
        reset = 1'b0;

        // default N=3 pulse mode
        expect_run("t1", 6, 32'b100100, 32'b001001);

        // load 5/half-duty at cnt=1; current period completes first
        step(1);
        pulse_load(5, 1'b1);
        expect_run("t2", 11, 32'b0_11100_11100, 32'b1_00001_00001);

        // two loads in one period: only the last is applied
        pulse_load(4, 1'b0);
        step(1);
        pulse_load(7, 1'b0);
        expect_run("t3", 9, 32'b00_1000000, 32'b01_0000001);

        // load coincident with the wrap applies immediately
        step(6);
        pulse_load(2, 1'b0);
        expect_run("t4", 4, 32'b1010, 32'b0101);

        // invalid loads: one-cycle error, period unaffected
        pulse_load(0, 1'b0);
        chk("t5_err_div0", div_err, 1'b1);
        pulse_load(1, 1'b0);
        chk("t5_err_div1", div_err, 1'b1);
        step(1);
        chk("t5_err_clear", div_err, 1'b0);
        expect_run("t5", 3, 32'b010, 32'b101);
        // invalid load on the wrap still lets a staged value through
        pulse_load(6, 1'b1);
        pulse_load(1, 1'b0);
        chk("t5_err_wrap", div_err, 1'b1);
        expect_run("t5b", 6, 32'b111000, 32'b000001);

        // en low at the last count: everything holds, tick stays high
        step(5);
        en = 1'b0;
        expect_run("t6_hold", 5, 32'b00000, 32'b11111);
        en = 1'b1;
        step(1);
        pulse_load(9, 1'b0);
        reset = 1'b1;
        step(1);
        chk("t6_reset_q", q, 1'b1);
        chk("t6_reset_tick", tick, 1'b0);
        chk("t6_reset_err", div_err, 1'b0);
        reset = 1'b0;
        expect_run("t6_after", 6, 32'b100100, 32'b001001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
